periph_target_regfile: RTL



---
 rtl/periph_target_regfile.sv | 87 ++++++++
 1 files changed

// File: rtl/periph_target_regfile.sv
// periph_target_regfile: byte-writable register file target with fixed wait states and out-of-range error responses
module periph_target_regfile #(
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    BYTE_ENABLE_BIT = DATA_WIDTH/8,
   parameter int                    NUM_REGS        = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int                    WAIT_CYCLES     = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         data_req_i,
   input  logic [ADDR_WIDTH-1:0]        data_add_i,
   input  logic                         data_we_n_i,
   input  logic [DATA_WIDTH-1:0]        data_wdata_i,
   input  logic [BYTE_ENABLE_BIT-1:0]   data_be_i,
   output logic                         data_gnt_o,
   output logic                         data_r_valid_o,
   output logic                         data_r_opc_o,
   output logic [DATA_WIDTH-1:0]        data_r_rdata_o,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
   localparam int BW = $clog2(BYTE_ENABLE_BIT);
   localparam int IW = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS*BYTE_ENABLE_BIT);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t                state;
   logic [3:0]            cnt;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [ADDR_WIDTH-1:0] off;
   logic [IW-1:0]         idx;
   logic                  in_range, nxt_opc, cap_opc;
   logic [DATA_WIDTH-1:0] nxt_rdata, cap_rdata;
   always_comb begin
      off        = data_add_i - BASE_ADDR;
      idx        = off[BW +: IW];
      in_range   = off < SPAN;
      nxt_opc    = ~in_range;
      nxt_rdata  = (in_range && data_we_n_i) ? regs[idx] : '0;
      data_gnt_o = data_req_i & ~rst_i & (state != WAIT);
   end
   // the response fields are held in cap_* while waiting so the outputs stay 0 until RESP
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         cnt            <= '0;
         cap_opc        <= 1'b0;
         cap_rdata      <= '0;
         data_r_valid_o <= 1'b0;
         data_r_opc_o   <= 1'b0;
         data_r_rdata_o <= '0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else begin
         data_r_valid_o <= 1'b0;
         data_r_opc_o   <= 1'b0;
         data_r_rdata_o <= '0;
         if (data_gnt_o) begin
            if (in_range && !data_we_n_i)
               for (int i = 0; i < BYTE_ENABLE_BIT; i++)
                  if (data_be_i[i]) regs[idx][i*8 +: 8] <= data_wdata_i[i*8 +: 8];
            cap_opc   <= nxt_opc;
            cap_rdata <= nxt_rdata;
            if (WAIT_CYCLES == 0) begin
               state          <= RESP;
               data_r_valid_o <= 1'b1;
               data_r_opc_o   <= nxt_opc;
               data_r_rdata_o <= nxt_rdata;
            end else begin
               state <= WAIT;
               cnt   <= 4'(WAIT_CYCLES - 1);
            end
         end else if (state == WAIT) begin
            if (cnt == '0) begin
               state          <= RESP;
               data_r_valid_o <= 1'b1;
               data_r_opc_o   <= cap_opc;
               data_r_rdata_o <= cap_rdata;
            end else
               cnt <= cnt - 1'b1;
         end else
            state <= IDLE;
      end
   end
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end
endmodule
